disp_arbiter: RTL
=================

DISP_ARBITER -- requirements
Module: disp_arbiter

Parameters
REQ-001 REFRESH_DIV, default 400000, clk cycles each digit is lit (100 MHz clock, 16 ms full refresh over 4 digits).
REQ-002 HOLD_CYCLES, default 100000000, minimum clk cycles an owner keeps the display before it can be preempted.

Interface
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 rst_n  input  1  reset.
REQ-005 req_a  input  1  requester A wants the display (level).
REQ-006 bcd_a  input  16  requester A digits, [3:0]=digit0 (rightmost) .. [15:12]=digit3.
REQ-007 req_b  input  1  requester B wants the display (level).
REQ-008 bcd_b  input  16  requester B digits, same packing.
REQ-009 gnt_a  output  1  A owns the display.
REQ-010 gnt_b  output  1  B owns the display.
REQ-011 an  output  4  digit anodes, active-low, one-hot-zero.
REQ-012 digit  output  4  BCD nibble for the lit digit, to the seven-segment decoder.
REQ-013 One clock; reset is asynchronous and active-low; clock port named clk, reset port named rst_n.

Function
REQ-014 FSM states IDLE, OWN_A, OWN_B; gnt_a=1 only in OWN_A, gnt_b=1 only in OWN_B; never both.
REQ-015 IDLE: an=4'b1111, digit=4'hF; scan counters keep running.
REQ-016 IDLE with exactly one req high -> that owner state on the next edge (grant latency 1 cycle).
REQ-017 IDLE with both req high -> the requester not in last_owner wins; last_owner updates on every grant.
REQ-018 OWN_x with req_x low -> OWN_y if req_y high, else IDLE, on the next edge.
REQ-019 OWN_x with req_x high, req_y high, hold count >= HOLD_CYCLES -> OWN_y (preemption).
REQ-020 OWN_x with req_x high and (req_y low or hold count < HOLD_CYCLES) -> stay.
REQ-021 Hold counter clears on every grant or ownership change, increments each cycle in OWN_x, saturates at HOLD_CYCLES.
REQ-022 Scan: slot counter 0..REFRESH_DIV-1 wraps to 0 and advances digit index 0->1->2->3->0; REFRESH_DIV=1 advances every cycle.
REQ-023 Anode map while owned: index0 -> 1110, 1 -> 1101, 2 -> 1011, 3 -> 0111.
REQ-024 an and digit are registered; they reflect the current owner's bus nibble for the current index, one cycle after the index or owner changes.
REQ-025 Owner change does not reset the digit index or slot counter.
REQ-026 Nibbles > 9 pass through unchanged; the decoder blanks them.
REQ-027 Bus data is sampled live, not latched at grant.

Reset
REQ-028 rst_n low asynchronously forces IDLE, gnt_a=0, gnt_b=0, an=4'b1111, digit=4'hF, all counters 0, last_owner=B (A wins the first tie).
REQ-029 Reset mid-ownership drops the grant immediately, with no completion of the current slot.

Structure
REQ-030 A shared package holds the state encoding (IDLE=2'd0, OWN_A=2'd1, OWN_B=2'd2), the anode patterns, and the blank constants 4'b1111/4'hF.
REQ-031 One sub-module, disp_scan: slot counter, digit index, and anode pattern, with parameter REFRESH_DIV.
REQ-032 Arbitration FSM and the data mux stay in disp_arbiter.

Verification (REFRESH_DIV=4, HOLD_CYCLES=8)
REQ-033 After reset, req_a=1, bcd_a=16'h1234 -> gnt_a=1 after 1 cycle; digit sequence 4,3,2,1 with an 1110,1101,1011,0111, each lasting 4 cycles.
REQ-034 req_a and req_b rise on the same edge after reset -> gnt_a; drop both, raise both again -> gnt_b.
REQ-035 OWN_A with req_b=1 from cycle 2 of ownership -> gnt_a held through hold count 8, then gnt_b=1 on the next edge; digit index continues without restarting.
REQ-036 OWN_B, req_b falls while req_a=1 -> OWN_A on the next edge without passing through IDLE; bcd_b=16'h00AF shows nibbles F,A,0,0 unchanged.
REQ-037 rst_n pulsed low mid-slot in OWN_A -> gnt_a=0, an=1111, digit=F asynchronously; after release with req_a held -> regrant 1 cycle later, scan starting at index0.

Source files
------------

// File: rtl/disp_arbiter_pkg.sv
// +------------------------------------------------------------------------+
// | disp_arbiter_pkg                                                       |
// | Shared state encoding and display constants for the display arbiter.  |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

package disp_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  localparam logic [3:0] c_an_blank    = 4'b1111;
  localparam logic [3:0] c_digit_blank = 4'hF;
  localparam logic [3:0] c_an_dig0     = 4'b1110;
  localparam logic [3:0] c_an_dig1     = 4'b1101;
  localparam logic [3:0] c_an_dig2     = 4'b1011;
  localparam logic [3:0] c_an_dig3     = 4'b0111;

  function automatic logic [3:0] anode_pattern(input logic [1:0] idx);
    case (idx)
      2'd0:    return c_an_dig0;
      2'd1:    return c_an_dig1;
      2'd2:    return c_an_dig2;
      default: return c_an_dig3;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/disp_scan.sv
// +------------------------------------------------------------------------+
// | disp_scan                                                              |
// | Free-running refresh slot counter, digit index and anode pattern.     |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

module disp_scan
  import disp_arbiter_pkg::*;
#(
  parameter int REFRESH_DIV = 400000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [1:0] o_idx,
  output logic [3:0] o_an_pat
);

  localparam int SLOT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [SLOT_W-1:0] c_slot_last = SLOT_W'(REFRESH_DIV - 1);

  logic [SLOT_W-1:0] r_slot;
  logic [1:0]        r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot <= '0;
      r_idx  <= '0;
    end else if (r_slot == c_slot_last) begin
      r_slot <= '0;
      r_idx  <= r_idx + 2'd1;
    end else begin
      r_slot <= r_slot + SLOT_W'(1);
    end
  end

  assign o_idx    = r_idx;
  assign o_an_pat = anode_pattern(r_idx);

endmodule

`default_nettype wire

// File: rtl/disp_arbiter.sv
// +------------------------------------------------------------------------+
// | disp_arbiter                                                           |
// | Two-requester seven-segment display arbiter with hold-time preemption.|
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

module disp_arbiter
  import disp_arbiter_pkg::*;
#(
  parameter int REFRESH_DIV = 400000,
  parameter int HOLD_CYCLES = 100000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_a,
  input  logic [15:0] bcd_a,
  input  logic        req_b,
  input  logic [15:0] bcd_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic [3:0]  an,
  output logic [3:0]  digit
);

  localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [HOLD_W-1:0] c_hold_max = HOLD_W'(HOLD_CYCLES);

  state_t            r_state;
  logic [HOLD_W-1:0] r_hold;
  logic              r_last_a;
  logic              r_gnt_a;
  logic              r_gnt_b;
  logic [3:0]        r_an;
  logic [3:0]        r_digit;

  logic [1:0]  w_idx;
  logic [3:0]  w_an_pat;
  logic [15:0] w_bus;
  logic [3:0]  w_nibble;
  logic        w_hold_done;

  disp_scan #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .o_idx    (w_idx),
    .o_an_pat (w_an_pat)
  );

  assign w_hold_done = (r_hold >= c_hold_max);
  assign w_bus       = (r_state == OWN_A) ? bcd_a : bcd_b;
  assign w_nibble    = w_bus[{w_idx, 2'b00} +: 4];

  // Every grant or ownership change clears the hold count and records the new owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_hold   <= '0;
      r_last_a <= 1'b0;
      r_gnt_a  <= 1'b0;
      r_gnt_b  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_a && (!req_b || !r_last_a)) begin
            r_state <= OWN_A; r_gnt_a <= 1'b1; r_gnt_b <= 1'b0;
            r_hold  <= '0;    r_last_a <= 1'b1;
          end else if (req_b) begin
            r_state <= OWN_B; r_gnt_a <= 1'b0; r_gnt_b <= 1'b1;
            r_hold  <= '0;    r_last_a <= 1'b0;
          end
        end
        OWN_A: begin
          if (req_b && (!req_a || w_hold_done)) begin
            r_state <= OWN_B; r_gnt_a <= 1'b0; r_gnt_b <= 1'b1;
            r_hold  <= '0;    r_last_a <= 1'b0;
          end else if (!req_a) begin
            r_state <= IDLE;  r_gnt_a <= 1'b0; r_gnt_b <= 1'b0;
            r_hold  <= '0;
          end else if (!w_hold_done) begin
            r_hold <= r_hold + HOLD_W'(1);
          end
        end
        OWN_B: begin
          if (req_a && (!req_b || w_hold_done)) begin
            r_state <= OWN_A; r_gnt_a <= 1'b1; r_gnt_b <= 1'b0;
            r_hold  <= '0;    r_last_a <= 1'b1;
          end else if (!req_b) begin
            r_state <= IDLE;  r_gnt_a <= 1'b0; r_gnt_b <= 1'b0;
            r_hold  <= '0;
          end else if (!w_hold_done) begin
            r_hold <= r_hold + HOLD_W'(1);
          end
        end
        default: begin
          r_state <= IDLE; r_gnt_a <= 1'b0; r_gnt_b <= 1'b0;
          r_hold  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an    <= c_an_blank;
      r_digit <= c_digit_blank;
    end else if (r_state == OWN_A || r_state == OWN_B) begin
      r_an    <= w_an_pat;
      r_digit <= w_nibble;
    end else begin
      r_an    <= c_an_blank;
      r_digit <= c_digit_blank;
    end
  end

  assign gnt_a = r_gnt_a;
  assign gnt_b = r_gnt_b;
  assign an    = r_an;
  assign digit = r_digit;

endmodule

`default_nettype wire
